// File: rtl/writeback_queue_if.sv
// Writeback queue bus: producer handshake, register-file write port and forwarding lookups.
interface writeback_queue_if #(
  parameter int unsigned D = 5,
  parameter int unsigned W = 32,
  parameter int unsigned N = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [D-1:0]          in_rd;
  logic [W-1:0]          in_data;
  logic [D-1:0]          wr_addr;
  logic [W-1:0]          wr_data;
  logic                  wr_en;
  logic [D-1:0]          rs1;
  logic [D-1:0]          rs2;
  logic                  fwd1_hit;
  logic                  fwd2_hit;
  logic [W-1:0]          fwd1_data;
  logic [W-1:0]          fwd2_data;
  logic [$clog2(N):0]    count;

  modport master (
    output in_valid, in_rd, in_data, rs1, rs2,
    input  in_ready, wr_addr, wr_data, wr_en, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
  );

  modport slave (
    input  in_valid, in_rd, in_data, rs1, rs2,
    output in_ready, wr_addr, wr_data, wr_en, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
  );
endinterface

// File: rtl/writeback_queue.sv
// Circular writeback FIFO that drains one result per cycle into the register file
// and forwards the youngest pending value for two source-register lookups.
module writeback_queue #(
  parameter int unsigned D = 5,
  parameter int unsigned W = 32,
  parameter int unsigned N = 4
) (
  input  logic              clk,
  input  logic              rst,
  writeback_queue_if.slave  bus
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [D-1:0]  rd_mem_q   [N];
  logic [W-1:0]  data_mem_q [N];
  logic          push;
  logic          pop;
  logic [PW-1:0] idx;

  // Handshake: results to register 0 complete the handshake but are dropped.
  always_comb begin
    bus.in_ready = (count_q < CW'(N));
    push         = bus.in_valid && bus.in_ready && (bus.in_rd != '0);
    pop          = (count_q != '0);
  end

  always_comb begin
    wr_ptr_d = push ? PW'(wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? PW'(rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d  = CW'(count_q + CW'(push) - CW'(pop));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload needs no reset: validity comes from pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= bus.in_rd;
      data_mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // Head entry is held stable between edges for the negedge register-file write.
  always_comb begin
    bus.wr_en   = pop;
    bus.wr_addr = pop ? rd_mem_q[rd_ptr_q]   : '0;
    bus.wr_data = pop ? data_mem_q[rd_ptr_q] : '0;
    bus.count   = count_q;
  end

  // Scan oldest to youngest so the last match seen is the youngest pending value.
  always_comb begin
    bus.fwd1_hit  = 1'b0;
    bus.fwd2_hit  = 1'b0;
    bus.fwd1_data = '0;
    bus.fwd2_data = '0;
    idx           = '0;
    for (int unsigned a = 0; a < N; a++) begin
      idx = PW'(rd_ptr_q + PW'(a));
      if (CW'(a) < count_q) begin
        if ((bus.rs1 != '0) && (rd_mem_q[idx] == bus.rs1)) begin
          bus.fwd1_hit  = 1'b1;
          bus.fwd1_data = data_mem_q[idx];
        end
        if ((bus.rs2 != '0) && (rd_mem_q[idx] == bus.rs2)) begin
          bus.fwd2_hit  = 1'b1;
          bus.fwd2_data = data_mem_q[idx];
        end
      end
    end
  end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL have parameter D, default 5, register address width (2^D registers).
REQ-002 The block SHALL have parameter W, default 32, data word width.
REQ-003 The block SHALL have parameter N, default 4, queue depth in entries (power of 2, >=2).
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port in_valid  input  1  producer offers a result.
REQ-007 The block SHALL have port in_ready  output  1  queue accepts a result this cycle.
REQ-008 The block SHALL have port in_rd  input  D  destination register of the offered result.
REQ-009 The block SHALL have port in_data  input  W  offered result value.
REQ-010 The block SHALL have port wr_addr  output  D  register-file write address (address3 side).
REQ-011 The block SHALL have port wr_data  output  W  register-file write data.
REQ-012 The block SHALL have port wr_en  output  1  register-file write enable.
REQ-013 The block SHALL have ports rs1, rs2  input  D each  forwarding lookup addresses.
REQ-014 The block SHALL have ports fwd1_hit, fwd2_hit  output  1 each  pending write to rs1/rs2 exists.
REQ-015 The block SHALL have ports fwd1_data, fwd2_data  output  W each  youngest pending value for rs1/rs2.
REQ-016 The block SHALL have port count  output  clog2(N)+1  number of valid entries.

Function
REQ-017 Storage SHALL be a circular FIFO of N entries {rd, data}, write pointer, read pointer, occupancy count.
REQ-018 in_ready SHALL equal (count < N); no same-cycle bypass when full.
REQ-019 Accept SHALL occur on posedge when in_valid && in_ready; entry stored at write pointer, pointer increments modulo N.
REQ-020 An accepted result with in_rd == 0 SHALL be consumed (handshake completes) but not stored; count unchanged by it.
REQ-021 wr_en SHALL equal (count != 0), combinational; wr_addr/wr_data SHALL equal the head entry; when count == 0, wr_addr = 0 and wr_data = 0.
REQ-022 Head SHALL pop on every posedge where wr_en is high; read pointer increments modulo N. Outputs stay stable from posedge to next posedge so the register file's negedge write samples them.
REQ-023 Latency: result accepted at posedge k into empty queue SHALL drive wr_en high during cycle k..k+1 and be popped at posedge k+1.
REQ-024 Simultaneous accept and pop SHALL leave count unchanged; accept while full SHALL not occur (in_ready low) even if pop happens that edge.
REQ-025 Writes SHALL leave the queue in acceptance order; drain rate one entry per cycle.
REQ-026 fwdX_hit SHALL be 1 iff rsX != 0 and some valid entry has rd == rsX; fwdX_data SHALL be the data of the youngest such entry, else 0; purely combinational on current state.
REQ-027 Lookups SHALL include the head entry being written this cycle; they SHALL NOT include the input being offered this cycle.
REQ-028 Pointers SHALL wrap from N-1 to 0 with no lost or duplicated entries.

Reset
REQ-029 rst high SHALL immediately (asynchronously) clear pointers and count to 0; wr_en = 0, wr_addr = 0, wr_data = 0, fwd hits = 0, fwd data = 0, in_ready = 1.
REQ-030 Reset mid-operation SHALL discard all pending entries; no register-file write SHALL be issued for them after rst asserts.
REQ-031 After rst deasserts, the first accept SHALL occur no earlier than the next posedge.

Verification
REQ-032 Single result: in_rd=5, in_data=0xDEADBEEF at edge 1 -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF in cycle 1; count back to 0 after edge 2.
REQ-033 Full: offer 5 results (rd=1..5) back-to-back with pops blocked by holding count (drain paused not possible) -> instead offer results every cycle: count never exceeds N=4, in_ready=0 only when count==4, rf sees rd 1..5 in order.
REQ-034 rd=0: accept in_rd=0, in_data=0x1234 -> in_ready handshake completes, count stays 0, wr_en stays 0.
REQ-035 Forwarding: queue holds rd=3 data 0x11 (older) and rd=3 data 0x22 (younger), rs1=3, rs2=0 -> fwd1_hit=1, fwd1_data=0x22, fwd2_hit=0, fwd2_data=0.
REQ-036 Wrap: push 10 results rd=1..10 data=rd*0x10 continuously -> register file receives exactly 10 writes in order with matching data, pointers wrap twice.
REQ-037 Reset mid-stream: with count=3, assert rst between edges -> wr_en, count, fwd hits drop to 0 immediately; after release no stale writes appear.
